// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: round-robin sequencer turning register read/write requests into I2C master command streams
// Optional per-command watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_txn_sequencer #(
    parameter logic [15:0] DIVISOR_INIT   = 16'hFFFF,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_rw,
    input  logic [13:0] req_dev,
    input  logic [15:0] req_reg,
    input  logic [15:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_nack,
    output logic        rsp_err,
    input  logic        cfg_div_wr,
    input  logic [15:0] cfg_div,
    output logic [15:0] dbl_clock_divisor,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_wdata,
    output logic        cmd_nack_last,
    input  logic        done_valid,
    input  logic [7:0]  done_rdata,
    input  logic        done_nack
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [2:0] OP_START = 3'd0, OP_WRITE = 3'd1, OP_READ = 3'd2, OP_STOP = 3'd3, OP_RESTART = 3'd4;

    state_t      state, state_nx;
    logic [2:0]  step, stop_step, op;
    logic        owner, last_grant, rw, nack, grant, gp, tmo, err_flag, pend;
    logic [6:0]  dev;
    logic [7:0]  reg_addr, wdata, rdata, wbyte;
    logic [15:0] pend_div;

    assign grant     = state == IDLE && |req_valid;
    assign gp        = &req_valid ? ~last_grant : req_valid[1];
    assign stop_step = rw ? 3'd6 : 3'd4;
    // Step index maps to op: write S,W,W,W,P / read S,W,W,RS,W,R,P
    assign op        = step == 3'd0 ? OP_START :
                       step == stop_step ? OP_STOP :
                       rw && step == 3'd3 ? OP_RESTART :
                       rw && step == 3'd5 ? OP_READ : OP_WRITE;
    assign wbyte     = step == 3'd1 ? {dev, 1'b0} : step == 3'd2 ? reg_addr : rw ? {dev, 1'b1} : wdata;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [23:0] wdog;
    logic        err;
    assign tmo      = (state == ISSUE || state == WAIT) && wdog == TIMEOUT_CYCLES - 24'd1;
    assign err_flag = err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= 24'd0;
            err  <= 1'b0;
        end else begin
            if (state_nx == ISSUE && state != ISSUE)
                wdog <= 24'd0;
            else if (state == ISSUE || state == WAIT)
                wdog <= wdog + 24'd1;
            if (grant)
                err <= 1'b0;
            else if (tmo)
                err <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo        = 1'b0;
    assign err_flag   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant ? ISSUE : IDLE;
            ISSUE:   state_nx = tmo ? RESP : cmd_ready ? WAIT : ISSUE;
            WAIT:    state_nx = tmo ? RESP : !done_valid ? WAIT : op == OP_STOP ? RESP : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = grant ? (gp ? 2'b10 : 2'b01) : 2'b00;
        cmd_valid     = state == ISSUE;
        cmd_op        = cmd_valid ? op : OP_START;
        cmd_wdata     = cmd_valid && op == OP_WRITE ? wbyte : 8'h00;
        cmd_nack_last = cmd_valid && op == OP_READ;
        rsp_valid     = state != RESP ? 2'b00 : owner ? 2'b10 : 2'b01;
        rsp_rdata     = state == RESP ? rdata : 8'h00;
        rsp_nack      = state == RESP && nack;
        rsp_err       = state == RESP && err_flag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant        <= 1'b1;
            owner             <= 1'b0;
            rw                <= 1'b0;
            dev               <= 7'h00;
            reg_addr          <= 8'h00;
            wdata             <= 8'h00;
            rdata             <= 8'h00;
            nack              <= 1'b0;
            step              <= 3'd0;
            dbl_clock_divisor <= DIVISOR_INIT;
            pend              <= 1'b0;
            pend_div          <= 16'h0000;
        end else begin
            if (grant) begin
                owner    <= gp;
                rw       <= gp ? req_rw[1] : req_rw[0];
                dev      <= gp ? req_dev[13:7] : req_dev[6:0];
                reg_addr <= gp ? req_reg[15:8] : req_reg[7:0];
                wdata    <= gp ? req_wdata[15:8] : req_wdata[7:0];
                step     <= 3'd0;
                nack     <= 1'b0;
                rdata    <= 8'h00;
            end
            if (tmo) begin
                nack  <= 1'b0;
                rdata <= 8'h00;
            end else if (state == WAIT && done_valid) begin
                if (op == OP_READ)
                    rdata <= done_rdata;
                if (op == OP_WRITE && done_nack) begin
                    nack <= 1'b1;
                    step <= stop_step;
                end else
                    step <= step + 3'd1;
            end
            if (state == RESP)
                last_grant <= owner;
            // Divisor only moves between transactions; mid-transaction writes wait for IDLE
            if (state == RESP) begin
                dbl_clock_divisor <= cfg_div_wr ? cfg_div : pend ? pend_div : dbl_clock_divisor;
                pend              <= 1'b0;
            end else if (cfg_div_wr && state == IDLE && !grant)
                dbl_clock_divisor <= cfg_div;
            else if (cfg_div_wr) begin
                pend     <= 1'b1;
                pend_div <= cfg_div;
            end
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed table-driven bench for i2c_txn_sequencer with a scripted master
// Timeout behaviour checked according to I2C_SEQ_TIMEOUT_EN.
module tb_i2c_txn_sequencer;
    localparam logic [2:0] S = 3'd0, W = 3'd1, R = 3'd2, P = 3'd3, RS = 3'd4;
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [23:0] TMO = 24'd16;
`else
    localparam logic [23:0] TMO = 24'd1000000;
`endif

    logic        clk = 1'b0, rst_n = 1'b1;
    logic [1:0]  req_valid = '0, req_ready, req_rw = '0, rsp_valid;
    logic [13:0] req_dev = '0;
    logic [15:0] req_reg = '0, req_wdata = '0, cfg_div = '0, dbl_clock_divisor;
    logic [7:0]  rsp_rdata, cmd_wdata, done_rdata = '0;
    logic        rsp_nack, rsp_err, cfg_div_wr = 1'b0, cmd_valid, cmd_ready = 1'b0, cmd_nack_last;
    logic        done_valid = 1'b0, done_nack = 1'b0;
    logic [2:0]  cmd_op;

    i2c_txn_sequencer #(.DIVISOR_INIT(16'hFFFF), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_err(rsp_err), .cfg_div_wr(cfg_div_wr),
        .cfg_div(cfg_div), .dbl_clock_divisor(dbl_clock_divisor), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata), .cmd_nack_last(cmd_nack_last),
        .done_valid(done_valid), .done_rdata(done_rdata), .done_nack(done_nack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             port, rw;
        logic [6:0]       dev;
        logic [7:0]       rg, wd, ret;
        logic [3:0]       nack_at, n;
        logic             div_test;
        logic [0:6][2:0]  ops;
        logic [0:6][7:0]  bytes;
        logic [1:0]       e_rsp;
        logic [7:0]       e_rdata;
        logic             e_nack;
    } vec_t;

    vec_t vecs [6];
    int checks = 0, failures = 0;

    function automatic vec_t mk(input logic port, input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                                input logic [7:0] wd, input logic [7:0] ret, input logic [3:0] nack_at,
                                input logic [3:0] n, input logic div_test, input logic [0:6][2:0] ops,
                                input logic [0:6][7:0] bytes, input logic [1:0] e_rsp, input logic [7:0] e_rdata,
                                input logic e_nack);
        vec_t v;
        v.port = port; v.rw = rw; v.dev = dev; v.rg = rg; v.wd = wd; v.ret = ret; v.nack_at = nack_at;
        v.n = n; v.div_test = div_test; v.ops = ops; v.bytes = bytes; v.e_rsp = e_rsp; v.e_rdata = e_rdata;
        v.e_nack = e_nack;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load(input int i);
        if (vecs[i].port) begin
            req_rw[1] = vecs[i].rw; req_dev[13:7] = vecs[i].dev;
            req_reg[15:8] = vecs[i].rg; req_wdata[15:8] = vecs[i].wd;
        end else begin
            req_rw[0] = vecs[i].rw; req_dev[6:0] = vecs[i].dev;
            req_reg[7:0] = vecs[i].rg; req_wdata[7:0] = vecs[i].wd;
        end
    endtask

    task automatic request(input int i);
        logic ok;
        @(posedge clk); #1;
        req_rw = 2'($urandom); req_dev = 14'($urandom); req_reg = 16'($urandom); req_wdata = 16'($urandom);
        load(i);
        req_valid = vecs[i].port ? 2'b10 : 2'b01;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = |req_ready;
        end
        chk("req_ready", req_ready, vecs[i].port ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
    endtask

    task automatic wait_cmd(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (cmd_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic serve(input int i);
        logic ok;
        for (int k = 0; k < int'(vecs[i].n); k++) begin
            wait_cmd(ok);
            chk("cmd_seen", ok, 1);
            if (!ok) return;
            chk("cmd_op", cmd_op, vecs[i].ops[k]);
            if (vecs[i].ops[k] == W) chk("cmd_wdata", cmd_wdata, vecs[i].bytes[k]);
            chk("cmd_nack_last", cmd_nack_last, vecs[i].ops[k] == R);
            if (vecs[i].div_test) chk("div_hold", dbl_clock_divisor, 16'hFFFF);
            if (k == 0) begin
                @(negedge clk);
                chk("cmd_stable", {cmd_valid, cmd_op}, {1'b1, vecs[i].ops[0]});
            end
            cmd_ready = 1'b1;
            @(posedge clk); #1;
            cmd_ready = 1'b0;
            cfg_div_wr = vecs[i].div_test && k == 2;
            cfg_div = 16'h0100;
            @(posedge clk); #1;
            cfg_div_wr = 1'b0;
            done_valid = 1'b1;
            done_nack = k == int'(vecs[i].nack_at);
            done_rdata = vecs[i].ret;
            @(posedge clk); #1;
            done_valid = 1'b0;
            done_nack = 1'b0;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) break;
        end
        chk("rsp_valid", rsp_valid, vecs[i].e_rsp);
        chk("rsp_rdata", rsp_rdata, vecs[i].e_rdata);
        chk("rsp_nack", rsp_nack, vecs[i].e_nack);
        chk("rsp_err", rsp_err, 0);
        if (vecs[i].div_test) chk("div_in_resp", dbl_clock_divisor, 16'hFFFF);
        @(negedge clk);
        chk("rsp_pulse", {rsp_valid, cmd_valid}, 0);
        if (vecs[i].div_test) chk("div_applied", dbl_clock_divisor, 16'h0100);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic ok, seen, bad;
        vecs[0] = mk(1'b0, 1'b0, 7'h50, 8'h10, 8'hA5, 8'h77, 4'd15, 4'd5, 1'b0, {S, W, W, W, P, S, S},
                     {8'h00, 8'hA0, 8'h10, 8'hA5, 8'h00, 8'h00, 8'h00}, 2'b01, 8'h00, 1'b0);
        vecs[1] = mk(1'b1, 1'b1, 7'h50, 8'h20, 8'h00, 8'h3C, 4'd15, 4'd7, 1'b1, {S, W, W, RS, W, R, P},
                     {8'h00, 8'hA0, 8'h20, 8'h00, 8'hA1, 8'h00, 8'h00}, 2'b10, 8'h3C, 1'b0);
        vecs[2] = mk(1'b0, 1'b0, 7'h2A, 8'h05, 8'h11, 8'h99, 4'd1, 4'd3, 1'b0, {S, W, P, S, S, S, S},
                     {8'h00, 8'h54, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2'b01, 8'h00, 1'b1);
        vecs[3] = mk(1'b1, 1'b1, 7'h7F, 8'hFF, 8'h00, 8'h5A, 4'd1, 4'd3, 1'b0, {S, W, P, S, S, S, S},
                     {8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2'b10, 8'h00, 1'b1);
        vecs[4] = mk(1'b1, 1'b0, 7'h01, 8'h80, 8'h00, 8'hC3, 4'd15, 4'd5, 1'b0, {S, W, W, W, P, S, S},
                     {8'h00, 8'h02, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00}, 2'b10, 8'h00, 1'b0);
        vecs[5] = mk(1'b0, 1'b1, 7'h3C, 8'h01, 8'h00, 8'hE7, 4'd4, 4'd6, 1'b0, {S, W, W, RS, W, P, S},
                     {8'h00, 8'h78, 8'h01, 8'h00, 8'h79, 8'h00, 8'h00}, 2'b01, 8'h00, 1'b1);

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_nack", rsp_nack, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_op", cmd_op, 0);
        chk("rst_cmd_wdata", cmd_wdata, 0);
        chk("rst_cmd_nack_last", cmd_nack_last, 0);
        chk("rst_divisor", dbl_clock_divisor, 16'hFFFF);
        @(posedge clk); #1 rst_n = 1'b1;

        @(posedge clk); #1;
        load(0); load(4);
        req_valid = 2'b11;
        @(negedge clk);
        chk("rr_first", req_ready, 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        serve(0);
        load(0); load(4);
        req_valid = 2'b11;
        #1 chk("rr_second", req_ready, 2'b10);
        @(posedge clk); #1 req_valid = 2'b00;
        serve(4);

        for (int i = 0; i < 6; i++) begin
            request(i);
            serve(i);
        end

        @(posedge clk); #1;
        done_valid = 1'b1; done_nack = 1'b1; done_rdata = 8'hEE;
        @(negedge clk);
        chk("stray_done_a", {cmd_valid, rsp_valid}, 0);
        @(posedge clk); #1 done_valid = 1'b0; done_nack = 1'b0;
        @(negedge clk);
        chk("stray_done_b", {cmd_valid, rsp_valid}, 0);

        request(0);
        wait_cmd(ok);
        chk("hang_start", {ok, cmd_op}, {1'b1, S});
        cmd_ready = 1'b1;
        @(posedge clk); #1 cmd_ready = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        seen = 1'b0;
        for (int c = 1; c <= 16 && !seen; c++) begin
            @(negedge clk);
            seen = rsp_valid[0];
        end
        chk("tmo_seen", seen, 1);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_nack", rsp_nack, 0);
        chk("tmo_rdata", rsp_rdata, 0);
        @(negedge clk);
        chk("tmo_pulse", {rsp_valid, cmd_valid}, 0);
`else
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || cmd_valid) bad = 1'b1;
        end
        chk("no_tmo_wait", bad, 0);
`endif
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        cfg_div_wr = 1'b1; cfg_div = 16'h0042;
        @(posedge clk); #1 cfg_div_wr = 1'b0;
        @(negedge clk);
        chk("div_idle_write", dbl_clock_divisor, 16'h0042);

        request(0);
        wait_cmd(ok);
        cmd_ready = 1'b1;
        @(posedge clk); #1 cmd_ready = 1'b0;
        cfg_div_wr = 1'b1; cfg_div = 16'h1234;
        @(posedge clk); #1 cfg_div_wr = 1'b0; done_valid = 1'b1;
        @(posedge clk); #1 done_valid = 1'b0;
        wait_cmd(ok);
        chk("mid_cmd", {ok, cmd_op, cmd_wdata}, {1'b1, W, 8'hA0});
        chk("mid_div_pending", dbl_clock_divisor, 16'h0042);
        rst_n = 1'b0;
        #1;
        chk("arst_cmd", {cmd_valid, cmd_op, cmd_wdata}, 0);
        chk("arst_div", dbl_clock_divisor, 16'hFFFF);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("pend_dropped", dbl_clock_divisor, 16'hFFFF);
        chk("arst_idle", {cmd_valid, rsp_valid}, 0);

        @(posedge clk); #1;
        load(0); load(4);
        req_valid = 2'b11;
        @(negedge clk);
        chk("rr_after_reset", req_ready, 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        serve(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
